// File: rtl/score_bcd_scheduler_pkg.sv
// Shared types and widths for the score-to-BCD display scheduler.
package score_bcd_scheduler_pkg;

    localparam int BIN_W = 8;
    localparam int BCD_W = 12;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_t;

endpackage

// File: rtl/score_bcd_scheduler.sv
// Shares one external binary-to-BCD converter between the two player scores.
// A channel is pending when it has never been converted or its score differs
// from the value last sent to the converter. The granted score is held on
// conv_bin for SETTLE_CYCLES cycles, then the converter result is latched into
// that player's display register. Round-robin pointer breaks ties.
module score_bcd_scheduler
    import score_bcd_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2    // legal range 1..15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BIN_W-1:0] score_a,
    input  logic [BIN_W-1:0] score_b,
    output logic [BIN_W-1:0] conv_bin,
    input  logic [BCD_W-1:0] conv_bcd,
    output logic [BCD_W-1:0] bcd_a,
    output logic [BCD_W-1:0] bcd_b,
    output logic             valid_a,
    output logic             valid_b,
    output logic             done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_reg;
    ch_t                sel_reg;
    ch_t                rr_ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BIN_W-1:0]   shadow_a_reg;
    logic [BIN_W-1:0]   shadow_b_reg;
    logic [BIN_W-1:0]   conv_bin_reg;
    logic [BCD_W-1:0]   bcd_a_reg;
    logic [BCD_W-1:0]   bcd_b_reg;
    logic               valid_a_reg;
    logic               valid_b_reg;
    logic               done_reg;
    logic               busy_reg;

    logic               pend_a;
    logic               pend_b;
    logic               grant_req;
    ch_t                grant_ch;

    assign pend_a = !valid_a_reg || (score_a != shadow_a_reg);
    assign pend_b = !valid_b_reg || (score_b != shadow_b_reg);

    // Pick the channel to serve: a lone pending channel wins, otherwise rr_ptr decides.
    always_comb begin
        grant_req = pend_a || pend_b;
        grant_ch  = rr_ptr_reg;
        if (pend_a && !pend_b) begin
            grant_ch = CH_A;
        end else if (pend_b && !pend_a) begin
            grant_ch = CH_B;
        end
    end

    // Conversion sequencer: grant, wait for converter to settle, capture, release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sel_reg      <= CH_A;
            rr_ptr_reg   <= CH_A;
            cnt_reg      <= '0;
            shadow_a_reg <= '0;
            shadow_b_reg <= '0;
            conv_bin_reg <= '0;
            bcd_a_reg    <= '0;
            bcd_b_reg    <= '0;
            valid_a_reg  <= 1'b0;
            valid_b_reg  <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_req) begin
                        sel_reg   <= grant_ch;
                        cnt_reg   <= CNT_INIT;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SETTLE;
                        if (grant_ch == CH_A) begin
                            conv_bin_reg <= score_a;
                            shadow_a_reg <= score_a;
                        end else begin
                            conv_bin_reg <= score_b;
                            shadow_b_reg <= score_b;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                ST_CAPTURE: begin
                    if (sel_reg == CH_A) begin
                        bcd_a_reg   <= conv_bcd;
                        valid_a_reg <= 1'b1;
                    end else begin
                        bcd_b_reg   <= conv_bcd;
                        valid_b_reg <= 1'b1;
                    end
                    done_reg   <= 1'b1;
                    rr_ptr_reg <= ch_t'(~sel_reg);
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv_bin = conv_bin_reg;
    assign bcd_a    = bcd_a_reg;
    assign bcd_b    = bcd_b_reg;
    assign valid_a  = valid_a_reg;
    assign valid_b  = valid_b_reg;
    assign done     = done_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Bench for score_bcd_scheduler: two instances (settle 2 and settle 5), each
// fed by a behavioural converter and compared every cycle against a
// transaction-level model that tracks edges-until-capture per conversion.
module tb_score_bcd_scheduler;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: default settle time
    logic        reset0;
    logic [7:0]  sa0, sb0, conv_bin0;
    logic [11:0] conv_bcd0, bcd_a0, bcd_b0;
    logic        valid_a0, valid_b0, done0, busy0;

    // Instance 1: settle time 5
    logic        reset1;
    logic [7:0]  sa1, sb1, conv_bin1;
    logic [11:0] conv_bcd1, bcd_a1, bcd_b1;
    logic        valid_a1, valid_b1, done1, busy1;

    function automatic logic [11:0] to_bcd(input int v);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        return 12'((h << 8) | (t << 4) | u);
    endfunction

    assign conv_bcd0 = to_bcd(int'(conv_bin0));
    assign conv_bcd1 = to_bcd(int'(conv_bin1));

    score_bcd_scheduler #(.SETTLE_CYCLES(2)) dut0 (
        .clock(clock), .reset(reset0), .score_a(sa0), .score_b(sb0),
        .conv_bin(conv_bin0), .conv_bcd(conv_bcd0), .bcd_a(bcd_a0), .bcd_b(bcd_b0),
        .valid_a(valid_a0), .valid_b(valid_b0), .done(done0), .busy(busy0)
    );

    score_bcd_scheduler #(.SETTLE_CYCLES(5)) dut1 (
        .clock(clock), .reset(reset1), .score_a(sa1), .score_b(sb1),
        .conv_bin(conv_bin1), .conv_bcd(conv_bcd1), .bcd_a(bcd_a1), .bcd_b(bcd_b1),
        .valid_a(valid_a1), .valid_b(valid_b1), .done(done1), .busy(busy1)
    );

    // Transaction model: rem = edges left until capture, -1 when nothing in flight.
    typedef struct {
        int rem;
        int ch;
        int val;
        int conv;
        int shadow_a;
        int shadow_b;
        int valid_a;
        int valid_b;
        int bcd_a;
        int bcd_b;
        int rr;
        int done;
    } model_t;

    model_t m0, m1;
    int     grants0 = 0;

    task automatic model_reset(output model_t m);
        m.rem = -1; m.ch = 0; m.val = 0; m.conv = 0;
        m.shadow_a = 0; m.shadow_b = 0; m.valid_a = 0; m.valid_b = 0;
        m.bcd_a = 0; m.bcd_b = 0; m.rr = 0; m.done = 0;
    endtask

    task automatic model_step(inout model_t m, input int settle, input bit rst,
                              input int sa, input int sb, output bit granted);
        bit pa, pb;
        granted = 1'b0;
        if (rst) begin
            model_reset(m);
        end else begin
            m.done = 0;
            if (m.rem < 0) begin
                pa = (m.valid_a == 0) || (sa != m.shadow_a);
                pb = (m.valid_b == 0) || (sb != m.shadow_b);
                if (pa || pb) begin
                    m.ch   = (pa && pb) ? m.rr : (pb ? 1 : 0);
                    m.val  = (m.ch == 1) ? sb : sa;
                    m.conv = m.val;
                    if (m.ch == 1) m.shadow_b = sb; else m.shadow_a = sa;
                    m.rem  = settle + 1;
                    granted = 1'b1;
                end
            end else begin
                m.rem = m.rem - 1;
                if (m.rem == 0) begin
                    if (m.ch == 1) begin
                        m.bcd_b = int'(to_bcd(m.val)); m.valid_b = 1;
                    end else begin
                        m.bcd_a = int'(to_bcd(m.val)); m.valid_a = 1;
                    end
                    m.done = 1;
                    m.rr   = 1 - m.ch;
                    m.rem  = -1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("s2.conv_bin", 32'(conv_bin0), 32'(m0.conv));
        check("s2.bcd_a",    32'(bcd_a0),    32'(m0.bcd_a));
        check("s2.bcd_b",    32'(bcd_b0),    32'(m0.bcd_b));
        check("s2.valid_a",  32'(valid_a0),  32'(m0.valid_a));
        check("s2.valid_b",  32'(valid_b0),  32'(m0.valid_b));
        check("s2.done",     32'(done0),     32'(m0.done));
        check("s2.busy",     32'(busy0),     32'(m0.rem >= 0));
        check("s5.conv_bin", 32'(conv_bin1), 32'(m1.conv));
        check("s5.bcd_a",    32'(bcd_a1),    32'(m1.bcd_a));
        check("s5.bcd_b",    32'(bcd_b1),    32'(m1.bcd_b));
        check("s5.valid_a",  32'(valid_a1),  32'(m1.valid_a));
        check("s5.valid_b",  32'(valid_b1),  32'(m1.valid_b));
        check("s5.done",     32'(done1),     32'(m1.done));
        check("s5.busy",     32'(busy1),     32'(m1.rem >= 0));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        bit g0, g1;
        @(posedge clock);
        model_step(m0, 2, reset0, int'(sa0), int'(sb0), g0);
        model_step(m1, 5, reset1, int'(sa1), int'(sb1), g1);
        if (g0) grants0++;
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        model_reset(m0);
        model_reset(m1);
        reset0 = 1'b1; reset1 = 1'b1;
        sa0 = 8'd0; sb0 = 8'd0; sa1 = 8'd0; sb1 = 8'd0;
        run(3);
        check("s2.reset_bcd_a", 32'(bcd_a0), 32'h0);
        check("s2.reset_busy",  32'(busy0),  32'h0);
        reset0 = 1'b0; reset1 = 1'b0;

        // Boot: A then B converted, done pulses 4 cycles apart
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (done0) done_cnt++;
        end
        check("boot_done_pulses", 32'(done_cnt), 32'd2);
        check("boot_valid_b", 32'(valid_b0), 32'd1);
        check("boot_idle_busy", 32'(busy0), 32'd0);

        // Single change on A to 255; instance 1 takes 0->128 with settle 5
        sa0 = 8'd255;
        sa1 = 8'd128;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (busy1) busy_cnt++;
            if (done0) done_cnt++;
        end
        check("a255_bcd_a", 32'(bcd_a0), 32'h255);
        check("a255_bcd_b", 32'(bcd_b0), 32'h000);
        check("a255_done_once", 32'(done_cnt), 32'd1);
        check("s5_a128_bcd_a", 32'(bcd_a1), 32'h128);
        check("s5_busy_cycles", 32'(busy_cnt), 32'd6);

        // Simultaneous change on both channels
        sa0 = 8'd99; sb0 = 8'd7;
        run(12);
        check("both_bcd_a", 32'(bcd_a0), 32'h099);
        check("both_bcd_b", 32'(bcd_b0), 32'h007);

        // B changes twice while A is settling
        sb0 = 8'd10;
        run(8);
        sa0 = 8'd100;
        cyc();
        sb0 = 8'd11;
        cyc();
        sb0 = 8'd12;
        run(12);
        check("midflight_bcd_a", 32'(bcd_a0), 32'h100);
        check("midflight_bcd_b", 32'(bcd_b0), 32'h012);

        // Reset in SETTLE drops the capture, then A=42 converts afresh
        sa0 = 8'd42;
        cyc();
        cyc();
        reset0 = 1'b1;
        cyc();
        check("rst_valid_a", 32'(valid_a0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        reset0 = 1'b0;
        run(14);
        check("rst_bcd_a", 32'(bcd_a0), 32'h042);

        // Randomised traffic on both instances with sparse resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) sa0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) sb0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) sa1 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) sb1 = 8'($urandom_range(0, 255));
            reset0 = ($urandom_range(0, 99) == 0);
            reset1 = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset0 = 1'b0; reset1 = 1'b0;
        run(30);
        check("final_bcd_a", 32'(bcd_a0), 32'(to_bcd(int'(sa0))));
        check("final_bcd_b", 32'(bcd_b0), 32'(to_bcd(int'(sb0))));
        check("s5_final_bcd_a", 32'(bcd_a1), 32'(to_bcd(int'(sa1))));
        check("s5_final_bcd_b", 32'(bcd_b1), 32'(to_bcd(int'(sb1))));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
